// File: rtl/profiler_pkg.sv
// Shared definitions for the stall-profiler frame streamer.
//   COUNTER_W      : width of one cumulative event counter
//   DEFAULT_HEADER : frame start byte
//   frame_len(n)   : bytes in a frame carrying n counters (header, seq, 4n delta bytes, checksum)
//   state_t        : streamer FSM states
//   checksum_fold  : folds one frame byte into the running XOR checksum
package profiler_pkg;

  localparam int         COUNTER_W      = 32;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int frame_len(input int n);
    return 4 * n + 3;
  endfunction

  function automatic logic [7:0] checksum_fold(input logic [7:0] sum, input logic [7:0] data);
    return sum ^ data;
  endfunction

endpackage

// File: rtl/profiler_interval_timer.sv
// Free-running sample interval timer.
//   clk, rst (async, active-high), enable : timer runs only while enable=1, cleared otherwise
//   tick                                  : high during the terminal-count cycle (count = SAMPLE_CYCLES-1)
module profiler_interval_timer #(
  parameter int SAMPLE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int             TW       = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [TW-1:0]  TERMINAL = TW'(SAMPLE_CYCLES - 1);

  logic [TW-1:0] count;

  // Interval counter: 0..SAMPLE_CYCLES-1, wraps on terminal count, held at 0 while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == TERMINAL) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

  // The terminal cycle is the one whose closing edge issues the periodic request.
  assign tick = enable && (count == TERMINAL);

endmodule

// File: rtl/profiler_frame_streamer.sv
// Snapshots the cumulative stall counters, computes per-interval deltas and streams them as a
// checksummed byte frame: HEADER, seq, delta[0..N-1] big-endian, XOR checksum (out_last).
//   clk, rst (async, active-high)
//   enable        : profiling enable; low clears the delta baseline and the interval timer
//   counters_in   : flat counter vector, counter k at [32k+31:32k]
//   trigger       : one-cycle manual snapshot request
//   out_data/out_valid/out_last/out_ready : byte stream toward the host link
//   busy          : frame in progress
//   dropped_count : saturating count of requests that arrived while a frame was in progress
module profiler_frame_streamer
  import profiler_pkg::*;
#(
  parameter int         NUM_COUNTERS  = 9,
  parameter int         SAMPLE_CYCLES = 1000000,
  parameter logic [7:0] HEADER        = DEFAULT_HEADER
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [COUNTER_W*NUM_COUNTERS-1:0] counters_in,
  input  logic                              trigger,
  output logic [7:0]                        out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic [15:0]                       dropped_count
);

  localparam int         FRAME_LEN = frame_len(NUM_COUNTERS);
  localparam int         DW        = COUNTER_W * NUM_COUNTERS;
  localparam logic [7:0] LAST_IDX  = 8'(FRAME_LEN - 1);

  state_t          state;
  logic [7:0]      idx;
  logic [7:0]      checksum;
  logic [7:0]      seq;
  logic [DW-1:0]   prev;
  logic [DW-1:0]   delta;

  logic            tick;
  logic            request;
  logic            xfer;
  logic [7:0]      next_idx;
  logic [7:0]      next_sum;
  logic [7:0]      next_byte;

  // Byte `off` of the delta payload: counter off>>2, most significant byte first.
  function automatic logic [7:0] delta_byte(input logic [DW-1:0] d, input logic [7:0] off);
    int lo;
    logic [7:0] b;
    if (int'(off) >= 4 * NUM_COUNTERS) begin
      b = 8'h00;
    end else begin
      lo = COUNTER_W * int'(off >> 2) + 8 * (3 - int'(off & 8'd3));
      b  = d[lo +: 8];
    end
    return b;
  endfunction

  profiler_interval_timer #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

  // Periodic and manual requests merge into a single request per cycle.
  assign request  = (tick | trigger) & enable;
  assign xfer     = out_valid & out_ready;
  assign next_idx = idx + 8'd1;
  assign next_sum = checksum_fold(checksum, out_data);

  // Byte presented after the current one is accepted.
  always_comb begin
    next_byte = 8'h00;
    if (next_idx == 8'd1) begin
      next_byte = seq;
    end else if (next_idx == LAST_IDX) begin
      next_byte = next_sum;
    end else begin
      next_byte = delta_byte(delta, next_idx - 8'd2);
    end
  end

  // Snapshot datapath: deltas latch on an accepted request; the baseline follows the upstream clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      delta <= '0;
    end else if (!enable) begin
      prev  <= '0;
    end else if ((state == IDLE) && request) begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        delta[k*COUNTER_W +: COUNTER_W] <= counters_in[k*COUNTER_W +: COUNTER_W]
                                           - prev[k*COUNTER_W +: COUNTER_W];
      end
      prev <= counters_in;
    end
  end

  // Frame FSM with registered stream outputs; a request seen in SEND (even on the last byte) is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 8'd0;
      checksum      <= 8'h00;
      seq           <= 8'h00;
      out_data      <= 8'h00;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      busy          <= 1'b0;
      dropped_count <= 16'h0000;
    end else begin
      if ((state == SEND) && request && (dropped_count != 16'hFFFF)) begin
        dropped_count <= dropped_count + 16'd1;
      end
      case (state)
        IDLE: begin
          if (request) begin
            state     <= SEND;
            idx       <= 8'd0;
            checksum  <= 8'h00;
            out_data  <= HEADER;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            checksum <= next_sum;
            idx      <= next_idx;
            if (out_last) begin
              state     <= IDLE;
              out_data  <= 8'h00;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              seq       <= seq + 8'd1;
            end else begin
              out_data <= next_byte;
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_profiler_frame_streamer.sv
// Scoreboard bench for profiler_frame_streamer (NUM_COUNTERS=9, SAMPLE_CYCLES=64).
// Inputs change 2 time units after the rising edge; the monitor samples on the falling edge.
module tb_profiler_frame_streamer;
  import profiler_pkg::*;

  localparam int N  = 9;
  localparam int SC = 64;
  localparam int L  = 4 * N + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic            trigger = 1'b0;
  logic            out_ready = 1'b0;
  logic [32*N-1:0] counters_in;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_last;
  logic            busy;
  logic [15:0]     dropped_count;

  logic [31:0] cnt [N];

  int errors = 0;
  int checks = 0;

  // Reference model state (frame-level view of the behaviour)
  logic [31:0] m_prev [N];
  logic [7:0]  m_seq   = 8'h00;
  int          m_timer = 0;
  bit          m_busy  = 1'b0;
  int          m_left  = 0;
  int          m_drop  = 0;
  logic [7:0]  exp_data [$];
  bit          exp_last [$];

  // Monitor bookkeeping
  int          frames_done   = 0;
  int          byte_in_frame = 0;
  logic [7:0]  last_seq      = 8'h00;
  bit          have_hold     = 1'b0;
  logic [7:0]  hold_data;
  logic        hold_last;
  logic [7:0]  e_data;
  bit          e_last;

  profiler_frame_streamer #(
    .NUM_COUNTERS (N),
    .SAMPLE_CYCLES(SC),
    .HEADER       (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .counters_in  (counters_in),
    .trigger      (trigger),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) counters_in[k*32 +: 32] = cnt[k];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_prev[k] = 32'd0;
    m_seq = 8'h00;
    m_timer = 0;
    m_busy = 1'b0;
    m_left = 0;
    m_drop = 0;
    exp_data.delete();
    exp_last.delete();
    byte_in_frame = 0;
  endtask

  // Advance the model across the coming rising edge using the inputs currently driven.
  task automatic model_edge();
    bit         tk, req, was_busy, xf;
    logic [31:0] d;
    logic [7:0]  sum;
    if (rst) begin
      model_reset();
      return;
    end
    tk       = enable && (m_timer == SC - 1);
    req      = (tk || trigger) && enable;
    was_busy = m_busy;
    xf       = was_busy && out_ready;
    if (req && !was_busy) begin
      exp_data.push_back(8'hA5);  exp_last.push_back(1'b0);
      exp_data.push_back(m_seq);  exp_last.push_back(1'b0);
      sum = 8'hA5 ^ m_seq;
      for (int k = 0; k < N; k++) begin
        d = cnt[k] - m_prev[k];
        for (int b = 3; b >= 0; b--) begin
          exp_data.push_back(d[8*b +: 8]);
          exp_last.push_back(1'b0);
          sum = sum ^ d[8*b +: 8];
        end
        m_prev[k] = cnt[k];
      end
      exp_data.push_back(sum);
      exp_last.push_back(1'b1);
      m_busy = 1'b1;
      m_left = L;
    end else if (req) begin
      if (m_drop < 65535) m_drop++;
    end
    if (xf) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_seq  = m_seq + 8'd1;
      end
    end
    if (!enable) begin
      for (int k = 0; k < N; k++) m_prev[k] = 32'd0;
      m_timer = 0;
    end else if (tk) begin
      m_timer = 0;
    end else begin
      m_timer++;
    end
  endtask

  task automatic step();
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
    check("dropped_count", {16'd0, dropped_count}, m_drop);
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && m_busy; i++) step();
    check("idle_reached", {31'd0, m_busy}, 32'd0);
  endtask

  // Scoreboard monitor: pops the expected byte on every handshake and watches stall stability.
  always @(negedge clk) begin
    if (rst) begin
      have_hold = 1'b0;
      byte_in_frame = 0;
    end else begin
      if (have_hold) begin
        check("valid_held", {31'd0, out_valid}, 32'd1);
        check("data_stable", {24'd0, out_data}, {24'd0, hold_data});
        check("last_stable", {31'd0, out_last}, {31'd0, hold_last});
      end
      if (out_valid && out_ready) begin
        have_hold = 1'b0;
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %h expected none at %0t", out_data, $time);
        end else begin
          e_data = exp_data.pop_front();
          e_last = exp_last.pop_front();
          check("byte", {24'd0, out_data}, {24'd0, e_data});
          check("last", {31'd0, out_last}, {31'd0, e_last});
          if (byte_in_frame == 1) last_seq = out_data;
          if (e_last) begin
            if (frames_done == 0) check("first_checksum", {24'd0, out_data}, 32'h000000A4);
            frames_done++;
            byte_in_frame = 0;
          end else begin
            byte_in_frame++;
          end
        end
      end else if (out_valid) begin
        have_hold = 1'b1;
        hold_data = out_data;
        hold_last = out_last;
      end else begin
        have_hold = 1'b0;
      end
    end
  end

  initial begin
    int f0;
    for (int k = 0; k < N; k++) begin
      cnt[k] = 32'd0;
      m_prev[k] = 32'd0;
    end
    @(posedge clk);
    #2;
    repeat (3) step();
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_out_last", {31'd0, out_last}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dropped", {16'd0, dropped_count}, 32'd0);

    // Periodic frames: counters k+1, then +5 each for the second interval
    rst = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) cnt[k] = 32'(k + 1);
    repeat (110) step();
    check("frames_after_first_tick", frames_done, 32'd1);
    for (int k = 0; k < N; k++) cnt[k] = cnt[k] + 32'd5;
    repeat (70) step();
    check("frames_after_second_tick", frames_done, 32'd2);

    // Counter wrap: baseline FFFFFFFE, then 3
    cnt[0] = 32'hFFFFFFFE;
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_idle();
    cnt[0] = 32'h00000003;
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_idle();

    // Random backpressure, triggers and counter updates
    repeat (300) begin
      out_ready = 1'($urandom_range(0, 1));
      trigger = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++) cnt[k] = $urandom;
      end
      step();
    end
    trigger = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // enable dropped mid-frame: frame completes, next delta is relative to zero
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (10) step();
    enable = 1'b0;
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (4) step();
    enable = 1'b1;
    wait_idle();
    for (int k = 0; k < N; k++) cnt[k] = $urandom;
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_idle();

    // Reset mid-frame aborts at once
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    model_reset();
    #1;
    repeat (2) step();
    rst = 1'b0;

    // Three triggers during a frame are dropped
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (4) step();
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (9) step();
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (9) step();
    trigger = 1'b1; step(); trigger = 1'b0;
    wait_idle();
    check("dropped_three", {16'd0, dropped_count}, 32'd3);
    check("seq_after_reset", {24'd0, last_seq}, 32'd0);

    // Trigger coincident with the periodic tick in IDLE: one frame only
    f0 = frames_done;
    for (int i = 0; i < 200 && m_timer != SC - 1; i++) step();
    check("reached_terminal", m_timer, 32'(SC - 1));
    trigger = 1'b1; step(); trigger = 1'b0;
    repeat (45) step();
    check("coincident_one_frame", frames_done, 32'(f0 + 1));
    check("dropped_unchanged", {16'd0, dropped_count}, 32'd3);
    check("scoreboard_empty", exp_data.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/profiler_frame_streamer.md
# profiler_frame_streamer

Downstream consumer of the stall profiling counters. Periodically, or on demand, it snapshots all cumulative 32-bit event counters and computes per-interval deltas. It emits each snapshot as a checksummed byte frame on a valid/ready stream, which feeds the host-link UART/DMA bridge.

## Interface
- NUM_COUNTERS, 9, number of 32-bit counters framed (1..32)
- SAMPLE_CYCLES, 1000000, clk cycles per periodic snapshot (≥ frame length + 2)
- HEADER, 8'hA5, frame start byte
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  profiling enable, the same signal the counter unit sees
- counters_in  in  32*NUM_COUNTERS  flat counter vector, counter k at bits [32k+31:32k]
- trigger  in  1  one-cycle manual snapshot request
- out_data  out  8  frame byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts the byte
- out_last  out  1  marks the checksum byte, the last in the frame
- busy  out  1  frame in progress (state ≠ IDLE)
- dropped_count  out  16  requests lost while busy, saturating

## Operation
- Interval timer:
  - Counts 0..SAMPLE_CYCLES-1 while enable=1.
  - A terminal count produces a periodic request, then the timer wraps to 0.
  - enable=0 clears the timer to 0.
- Request = (periodic request | trigger) & enable. Coincident sources count as one request.
- FSM states IDLE and SEND.
- IDLE + request, on the same edge:
  - snap[k] ← counters_in[k]
  - delta[k] ← counters_in[k] − prev[k] mod 2^32
  - prev[k] ← counters_in[k]
  - byte index ← 0, checksum ← 0, go to SEND.
- SEND, with frame length L = 4·NUM_COUNTERS + 3:
  - Byte 0 = HEADER.
  - Byte 1 = seq.
  - Bytes 2..L-2 = delta[0..N-1], each big-endian, MSB first.
  - Byte L-1 = XOR of bytes 0..L-2, with out_last=1.
- Transfer happens on out_valid & out_ready. Each transfer XORs the byte into the checksum and advances the index.
- Transfer of the last byte: seq ← seq+1 (8-bit wrap 255→0), return to IDLE.
- Request while in SEND: not serviced. dropped_count += 1, saturating at 16'hFFFF. prev is unchanged.
- enable=0:
  - prev[k] ← 0, matching the upstream counter clear.
  - Timer cleared, no new requests.
  - A frame already in SEND completes normally. Its deltas are already latched.
- Upstream counter wrap is handled by the modular subtraction, with no special case.

## Timing
- Reset values:
  - out_data=0, out_valid=0, out_last=0, busy=0, dropped_count=0.
  - seq=0, timer=0, all snap/delta/prev=0, state=IDLE.
- Request sampled at edge t → out_valid=1 with HEADER from t+1.
- Throughput is one byte per cycle while out_ready=1. A frame takes L cycles minimum (39 for N=9).
- Stream rules:
  - out_data and out_last are held stable while out_valid & ~out_ready.
  - out_valid is never withdrawn before acceptance.
  - out_valid=0 in IDLE.
- busy rises with the first out_valid and falls on the edge that accepts the last byte.
- A request on the same cycle the last byte is accepted counts as dropped. A new request is accepted only in IDLE.
- rst mid-frame aborts immediately. All outputs return to reset values asynchronously.

## Structure
- profiler_pkg holds:
  - COUNTER_W=32
  - default HEADER
  - frame_len(n) function = 4n+3
  - state enum {IDLE, SEND}
- Sub-module profiler_interval_timer provides the timer and terminal pulse: inputs clk, rst, enable; output tick.
- Byte selection: delta[(idx-2)>>2], byte 3-((idx-2)&3).

## Test plan
- Periodic frame:
  - Setup: SAMPLE_CYCLES=64, counters_in[k]=k+1, out_ready=1.
  - Required: frame A5,00, then 00,00,00,01 … 00,00,00,09, then checksum = XOR; out_last only on byte 38.
- Second frame delta:
  - Stimulus: counters +5 each, next tick.
  - Required: seq=01, each delta=00,00,00,05.
- Wrap:
  - Stimulus: prev[0]=FFFFFFFE, counters_in[0]=00000003.
  - Required: delta bytes 00,00,00,05.
- Backpressure:
  - Stimulus: out_ready toggling 1/0 randomly.
  - Required: byte sequence identical to the no-stall case; out_data stable during stalls.
- Drop:
  - Stimulus: trigger 3 times during a frame, plus trigger and tick coincident in IDLE.
  - Required: dropped_count=3; exactly one frame from the coincident request.
- Enable/reset:
  - Stimulus: enable=0 mid-frame.
  - Required: frame completes and the next delta is relative to 0.
  - Stimulus: rst mid-frame.
  - Required: out_valid=0 immediately; next frame has seq=00.
